// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with redirect support
module fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [29:0] pc,
  input  logic        instr_ready,
  input  logic        jmp_enable,
  input  logic [29:0] jmp_addr,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [29:0] fetch_pc;

  // The request address is the pending fetch address itself, so it is
  // stable for as long as the request is held.
  assign imem_addr = fetch_pc;

  // Fetch sequencer: one request outstanding, every output registered so
  // instr_ready never reaches imem_req combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      pc          <= 30'h0;
      retired     <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // instr_valid is always set here, so instr_ready alone marks a consume.
          if (instr_ready) begin
            fetch_pc    <= jmp_enable ? jmp_addr : pc + 30'd1;
            instr_valid <= 1'b0;
            retired     <= retired + 32'd1;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [29:0] RPC = 30'h10;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [29:0] pc;
  logic        instr_ready;
  logic        jmp_enable;
  logic [29:0] jmp_addr;
  logic [31:0] retired;

  int checks;
  int failures;

  // Reference model: address the next request must carry and consumed count.
  logic [29:0] exp_addr;
  logic [31:0] exp_retired;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready),
    .jmp_enable  (jmp_enable),
    .jmp_addr    (jmp_addr),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    jmp_enable  = 1'b0;
    jmp_addr    = 30'h0;
  endtask

  // Irrelevant-input noise; rv_ok/ir_ok select which strobes may toggle.
  task automatic noise(input bit rv_ok, input bit ir_ok);
    imem_ready  = 1'b0;
    imem_rvalid = rv_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_rdata  = $urandom;
    instr_ready = ir_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    jmp_enable  = 1'($urandom_range(0, 1));
    jmp_addr    = 30'($urandom);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'h0, imem_req}, 32'h1);
    chk("req_addr", {2'b0, imem_addr}, {2'b0, exp_addr});
  endtask

  // One full fetch/consume transaction with programmable stalls.
  task automatic fetch_one(input logic [31:0] data, input int rd, input int vd, input int hd,
                           input bit jmp, input logic [29:0] jaddr);
    wait_req();
    for (int i = 0; i < rd; i++) begin
      noise(1'b1, 1'b1);
      step();
      chk("req_hold", {31'h0, imem_req}, 32'h1);
      chk("req_addr_stable", {2'b0, imem_addr}, {2'b0, exp_addr});
      chk("req_no_valid", {31'h0, instr_valid}, 32'h0);
    end
    quiet();
    imem_ready = 1'b1;
    step();
    quiet();
    chk("wait_req_low", {31'h0, imem_req}, 32'h0);
    chk("wait_no_valid", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < vd; i++) begin
      noise(1'b0, 1'b1);
      step();
      chk("wait_stall_valid", {31'h0, instr_valid}, 32'h0);
      chk("wait_stall_req", {31'h0, imem_req}, 32'h0);
    end
    quiet();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    quiet();
    chk("hold_valid", {31'h0, instr_valid}, 32'h1);
    chk("hold_instr", instr, data);
    chk("hold_pc", {2'b0, pc}, {2'b0, exp_addr});
    chk("hold_req_low", {31'h0, imem_req}, 32'h0);
    chk("hold_retired", retired, exp_retired);
    for (int i = 0; i < hd; i++) begin
      noise(1'b1, 1'b0);
      step();
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_instr", instr, data);
      chk("stall_pc", {2'b0, pc}, {2'b0, exp_addr});
      chk("stall_retired", retired, exp_retired);
      chk("stall_req", {31'h0, imem_req}, 32'h0);
    end
    quiet();
    instr_ready = 1'b1;
    jmp_enable  = jmp;
    jmp_addr    = jaddr;
    step();
    quiet();
    exp_retired = exp_retired + 32'd1;
    exp_addr    = jmp ? jaddr : 30'(exp_addr + 30'd1);
    chk("consume_valid", {31'h0, instr_valid}, 32'h0);
    chk("consume_retired", retired, exp_retired);
    chk("next_req", {31'h0, imem_req}, 32'h1);
    chk("next_addr", {2'b0, imem_addr}, {2'b0, exp_addr});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_addr    = RPC;
    exp_retired = 32'h0;
    rst_n       = 1'b0;
    quiet();
    repeat (3) step();

    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", {2'b0, imem_addr}, {2'b0, RPC});
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", {2'b0, pc}, 32'h0);
    chk("rst_retired", retired, 32'h0);

    rst_n = 1'b1;
    #1;
    chk("boot_req_low", {31'h0, imem_req}, 32'h0);
    step();
    chk("boot_to_req", {31'h0, imem_req}, 32'h1);

    // First fetch at RESET_PC, zero-wait memory, consumed with a jump.
    fetch_one(32'h00000013, 0, 0, 0, 1'b1, 30'h200);
    // Stalled request then stalled consumer at the jump target.
    fetch_one(32'hA5A5_0001, 5, 0, 4, 1'b0, 30'h0);

    for (int k = 0; k < 20; k++) begin
      fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 30'($urandom));
    end

    // Sequential increment must wrap at the top of the 30-bit space.
    fetch_one($urandom, 0, 0, 0, 1'b1, 30'h3FFFFFFF);
    fetch_one($urandom, 0, 3, 0, 1'b0, 30'h0);
    chk("wrap_addr", {2'b0, imem_addr}, 32'h0);

    // Reset in WAIT abandons the request; a late response is dropped.
    wait_req();
    imem_ready = 1'b1;
    step();
    quiet();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr", {2'b0, imem_addr}, {2'b0, RPC});
    chk("mid_rst_retired", retired, 32'h0);
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    step();
    rst_n       = 1'b1;
    exp_addr    = RPC;
    exp_retired = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    quiet();
    chk("stale_valid", {31'h0, instr_valid}, 32'h0);
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", {2'b0, imem_addr}, {2'b0, RPC});
    step();
    chk("stale_valid2", {31'h0, instr_valid}, 32'h0);

    fetch_one(32'h1234_5678, 1, 1, 1, 1'b0, 30'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 30'h0, word address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: imem_req  output  1  instruction-memory request valid.
REQ-005 Port: imem_addr  output  30  word address of the request.
REQ-006 Port: imem_ready  input  1  memory accepts the request this cycle.
REQ-007 Port: imem_rvalid  input  1  read data valid.
REQ-008 Port: imem_rdata  input  32  instruction word.
REQ-009 Port: instr_valid  output  1  instr/pc hold a fetched instruction.
REQ-010 Port: instr  output  32  fetched instruction.
REQ-011 Port: pc  output  30  word address of instr.
REQ-012 Port: instr_ready  input  1  execute stage consumes instr this cycle.
REQ-013 Port: jmp_enable  input  1  redirect request from the branch controller, valid only in a consume cycle.
REQ-014 Port: jmp_addr  input  30  redirect target word address.
REQ-015 Port: retired  output  32  count of consumed instructions.

Function
REQ-016 Internal register fetch_pc (30 bit) shall hold the address of the next request.
REQ-017 States shall be BOOT, REQ, WAIT, HOLD; exactly one request outstanding at any time.
REQ-018 BOOT: imem_req=0; shall go to REQ on the first clock edge after rst_n deasserts.
REQ-019 REQ: imem_req=1, imem_addr=fetch_pc; on imem_ready -> WAIT; else stay REQ with address stable.
REQ-020 WAIT: imem_req=0; on imem_rvalid shall load instr=imem_rdata, pc=fetch_pc, instr_valid=1 -> HOLD.
REQ-021 HOLD: instr_valid=1, instr and pc stable; without instr_ready -> stay HOLD.
REQ-022 Consume = instr_valid && instr_ready: next fetch_pc = jmp_enable ? jmp_addr : pc+1; instr_valid clears; retired increments; -> REQ.
REQ-023 pc+1 shall wrap modulo 2^30 (30'h3FFFFFFF -> 30'h0); retired shall wrap modulo 2^32.
REQ-024 jmp_enable/jmp_addr shall be ignored in any cycle that is not a consume cycle.
REQ-025 imem_rvalid outside WAIT (BOOT, REQ, HOLD) shall be ignored with no state change.
REQ-026 imem_ready while imem_req=0 shall be ignored.
REQ-027 instr_valid shall be a register output; no combinational path from instr_ready to imem_req.
REQ-028 Minimum latency: request accepted cycle N, rvalid cycle N+1 -> instr_valid high cycle N+2; steady throughput 1 instruction per 3 cycles with zero-wait memory.

Reset
REQ-029 While rst_n=0: state=BOOT, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0, pc=30'h0, retired=32'h0.
REQ-030 Reset asserted in any state shall abandon the outstanding request; a response arriving after reset is ignored per REQ-025.
REQ-031 First request after reset shall target RESET_PC.

Verification
REQ-032 Reset release, RESET_PC=30'h10, ready/rvalid one cycle each, rdata=32'h00000013 -> imem_addr=30'h10, instr_valid with instr=32'h00000013, pc=30'h10.
REQ-033 Consume with jmp_enable=1, jmp_addr=30'h200 -> next imem_addr=30'h200, next pc=30'h200, retired=1.
REQ-034 imem_ready low 5 cycles in REQ -> imem_req held 1, imem_addr unchanged; instr_ready low 4 cycles in HOLD -> instr/pc stable, retired unchanged.
REQ-035 pc=30'h3FFFFFFF consumed, jmp_enable=0 -> next imem_addr=30'h0; jmp_enable=1 pulsed while in WAIT -> no effect.
REQ-036 rst_n pulsed low in WAIT, stale rvalid one cycle later -> instr_valid stays 0, next request to RESET_PC.
